// File: rtl/aes_pkg.sv
// Shared types, the FIPS-197 inverse S-box table and byte-level helpers
// for the AES inverse round datapath.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] state_t;

  // FIPS-197 inverse S-box, indexed by the input byte
  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  // Byte k = bits [127-8k -: 8]; row = k mod 4, column = k div 4.
  // Row r is rotated right by r: out[r][c] = in[r][(c - r) mod 4].
  function automatic state_t inv_shift_rows(state_t s);
    state_t r;
    r = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned row = 0; row < 4; row++) begin
        r[127 - 8 * (4 * c + row) -: 8] =
          s[127 - 8 * (4 * ((c + 4 - row) % 4) + row) -: 8];
      end
    end
    return r;
  endfunction

  function automatic state_t inv_sub_bytes(state_t s);
    state_t r;
    r = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      r[127 - 8 * k -: 8] = INV_SBOX[s[127 - 8 * k -: 8]];
    end
    return r;
  endfunction

  function automatic state_t add_round_key(state_t s, state_t k);
    return s ^ k;
  endfunction

endpackage

// File: rtl/aes_inv_sbox.sv
// 8-bit combinational FIPS-197 inverse S-box lookup.
module aes_inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] byte_val,
  output logic [7:0] sub_val
);

  // table lookup, pure combinational
  always_comb begin
    sub_val = INV_SBOX[byte_val];
  end

endmodule

// File: rtl/aes_inv_round_step.sv
// One registered AES inverse-cipher step: InvShiftRows -> InvSubBytes ->
// AddRoundKey, or AddRoundKey only when key_only is set.
// Optional macro AES_SBOX_PIPE_EN: adds a register after InvSubBytes,
// moving AddRoundKey to a second stage (latency 2).
module aes_inv_round_step
  import aes_pkg::*;
#(
  parameter int NB = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         key_only,
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  output logic         out_valid,
  output logic [127:0] state_out
);

  if (NB != 4) begin : g_nb_check
    $error("aes_inv_round_step: NB must be 4");
  end

  state_t shifted;
  state_t subbed;

  // row rotation is pure wiring
  always_comb begin
    shifted = inv_shift_rows(state_in);
  end

  for (genvar k = 0; k < 16; k++) begin : g_sbox
    aes_inv_sbox u_sbox (
      .byte_val (shifted[127 - 8 * k -: 8]),
      .sub_val  (subbed[127 - 8 * k -: 8])
    );
  end

`ifdef AES_SBOX_PIPE_EN

  logic   s1_valid;
  state_t s1_data;
  state_t s1_key;

  // stage 1: bypass select is resolved before the register, so key_only
  // travels as the choice of data rather than as a separate bit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_key   <= '0;
    end else begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data <= key_only ? state_in : subbed;
        s1_key  <= round_key;
      end
    end
  end

  // stage 2: AddRoundKey with the key captured alongside the data
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      state_out <= '0;
    end else begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        state_out <= add_round_key(s1_data, s1_key);
      end
    end
  end

`else

  // single stage: select full or key-only result and register it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      state_out <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        state_out <= add_round_key(key_only ? state_in : subbed, round_key);
      end
    end
  end

`endif

endmodule

// File: tb/tb_aes_inv_round_step.sv
// Self-checking bench for aes_inv_round_step: directed vectors plus random
// traffic against a reference built from GF(2^8) arithmetic.
module tb_aes_inv_round_step;

`ifdef AES_SBOX_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         key_only;
  logic [127:0] state_in;
  logic [127:0] round_key;
  logic         out_valid;
  logic [127:0] state_out;

  aes_inv_round_step #(.NB(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .key_only  (key_only),
    .state_in  (state_in),
    .round_key (round_key),
    .out_valid (out_valid),
    .state_out (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] inv_tab [256];

  // model pipeline: slot LAT-1 is what the outputs should show
  logic         pv [LAT];
  logic [127:0] pd [LAT];
  logic         exp_valid;
  logic [127:0] exp_state;

  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p;
    p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[0]) p = p ^ a;
      a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl(logic [7:0] x, int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // forward S-box from field inverse + affine map, then inverted
  task automatic build_inv_table();
    logic [7:0] inv, s;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
      inv_tab[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] ref_step(logic ko, logic [127:0] st, logic [127:0] key);
    logic [7:0]   m  [4][4];
    logic [7:0]   sh [4][4];
    logic [127:0] r;
    if (ko) return st ^ key;
    for (int k = 0; k < 16; k++) m[k % 4][k / 4] = st[127 - 8 * k -: 8];
    for (int row = 0; row < 4; row++)
      for (int c = 0; c < 4; c++)
        sh[row][c] = m[row][(c - row + 4) % 4];
    r = '0;
    for (int k = 0; k < 16; k++) r[127 - 8 * k -: 8] = inv_tab[sh[k % 4][k / 4]];
    return r ^ key;
  endfunction

  task automatic check1(string tag, logic got, logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  task automatic check128(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pd[i] = '0;
    end
    exp_valid = 1'b0;
    exp_state = '0;
  endtask

  // drive one cycle, advance the model at the edge, compare just after it
  task automatic cycle(logic v, logic ko, logic [127:0] st, logic [127:0] key);
    in_valid  = v;
    key_only  = ko;
    state_in  = st;
    round_key = key;
    @(posedge clk);
    for (int i = LAT - 1; i > 0; i--) begin
      pv[i] = pv[i - 1];
      pd[i] = pd[i - 1];
    end
    pv[0] = v;
    pd[0] = ref_step(ko, st, key);
    exp_valid = pv[LAT - 1];
    if (pv[LAT - 1]) exp_state = pd[LAT - 1];
    #1;
    check1("out_valid", out_valid, exp_valid);
    check128("state_out", state_out, exp_state);
  endtask

  localparam logic [127:0] V1_ST  = 128'haa5ece06ee6e3c56dde68bac2621bebf;
  localparam logic [127:0] V1_KEY = 128'h4e5a6699a9f24fe07e572baacdf8cdea;
  localparam logic [127:0] V1_EXP = 128'h2c21a820306f154ab712c75eee0da04f;
  localparam logic [127:0] V2_ST  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] V2_KEY = 128'h24fc79ccbf0979e9371ac23c6d68de36;

  initial begin
    logic [127:0] held;
    build_inv_table();
    model_clear();
    in_valid  = 1'b0;
    key_only  = 1'b0;
    state_in  = '0;
    round_key = '0;
    rst_n     = 1'b0;
    #12;
    check1("reset_valid", out_valid, 1'b0);
    check128("reset_state", state_out, 128'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // full-mode vector, with directed constant check once it emerges
    cycle(1'b1, 1'b0, V1_ST, V1_KEY);
    for (int i = 1; i < LAT; i++) cycle(1'b0, 1'b0, '0, '0);
    check128("full_vec", state_out, V1_EXP);
    check1("full_vec_valid", out_valid, 1'b1);
    cycle(1'b0, 1'b1, '1, '1);

    // key-only vector
    cycle(1'b1, 1'b1, V2_ST, V2_KEY);
    for (int i = 1; i < LAT; i++) cycle(1'b0, 1'b0, '0, '0);
    check128("keyonly_vec", state_out, V1_ST);
    cycle(1'b0, 1'b0, '0, '0);

    // S-box corners
    cycle(1'b1, 1'b0, '0, '0);
    for (int i = 1; i < LAT; i++) cycle(1'b0, 1'b0, '0, '0);
    check128("corner_zero", state_out, {16{8'h52}});
    cycle(1'b1, 1'b0, {16{8'h63}}, '1);
    for (int i = 1; i < LAT; i++) cycle(1'b0, 1'b0, '0, '0);
    check128("corner_63", state_out, '1);
    cycle(1'b0, 1'b0, '0, '0);

    // back-to-back, then idle with changing key/mode (must hold)
    cycle(1'b1, 1'b0, V1_ST, V1_KEY);
    cycle(1'b1, 1'b1, V2_ST, V2_KEY);
    for (int i = 1; i < LAT; i++) cycle(1'b0, 1'b1, '1, '1);
    held = state_out;
    check128("b2b_second", held, V1_ST);
    cycle(1'b0, 1'b0, V1_ST, 128'h0123456789abcdef0123456789abcdef);
    check1("b2b_idle_valid", out_valid, 1'b0);
    check128("b2b_hold", state_out, V1_ST);
    cycle(1'b0, 1'b1, V2_ST, V2_KEY);

    // asynchronous reset between edges while out_valid is high
    cycle(1'b1, 1'b0, V1_ST, V1_KEY);
    for (int i = 1; i < LAT; i++) cycle(1'b1, 1'b1, V2_ST, V2_KEY);
    check1("pre_reset_valid", out_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_clear();
    check1("async_rst_valid", out_valid, 1'b0);
    check128("async_rst_state", state_out, 128'h0);
    in_valid = 1'b0;
    @(posedge clk); #1;
    check1("rst_hold_valid", out_valid, 1'b0);
    #2;
    rst_n = 1'b1;
    cycle(1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, V1_ST, V1_KEY);
    for (int i = 1; i < LAT; i++) cycle(1'b0, 1'b0, '0, '0);
    check128("post_reset_vec", state_out, V1_EXP);

    // random traffic
    for (int n = 0; n < 200; n++) begin
      cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            {$urandom, $urandom, $urandom, $urandom},
            {$urandom, $urandom, $urandom, $urandom});
    end
    for (int i = 0; i < LAT; i++) cycle(1'b0, 1'b0, '0, '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
